// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: observer for a 4-digit active-low multiplexed 7-segment scan bus.
// Define FND_DEC_BLANK_AS_ZERO_EN to decode an all-off digit as 0 instead of an error.
module fnd_scan_decoder #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_data,
    output logic [13:0] value,
    output logic        value_vld,
    output logic        seg_err,
    output logic        timeout
);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d, stab_next;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]    mask_q, mask_d;
    logic [3:0]    err_q, err_d;
    logic [3:0]    dig_q [4];
    logic [3:0]    dig_d [4];
    logic [13:0]   value_q, value_d;
    logic          value_vld_q, value_vld_d;
    logic          seg_err_q, seg_err_d;
    logic          timeout_q, timeout_d;
    logic [10:0]   pair_q, pair;
    logic          same, is_onehot, sample;
    logic [1:0]    slot;
    logic [4:0]    dec;
    logic          unused_dp;

    assign unused_dp = fnd_data[7];
    assign pair      = {fnd_com, fnd_data[6:0]};
    assign same      = (pair == pair_q);

    // Returns {err, bcd}; anything outside the digit table is an error with bcd 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = 5'd0;
            7'h79:   r = 5'd1;
            7'h24:   r = 5'd2;
            7'h30:   r = 5'd3;
            7'h19:   r = 5'd4;
            7'h12:   r = 5'd5;
            7'h02:   r = 5'd6;
            7'h78:   r = 5'd7;
            7'h00:   r = 5'd8;
            7'h10:   r = 5'd9;
`ifdef FND_DEC_BLANK_AS_ZERO_EN
            7'h7F:   r = 5'd0;
`endif
            default: r = 5'b1_0000;
        endcase
        return r;
    endfunction

    function automatic logic [13:0] bcd4_to_bin(input logic [3:0] d3, input logic [3:0] d2,
                                                 input logic [3:0] d1, input logic [3:0] d0);
        return 14'(d3) * 14'd1000 + 14'(d2) * 14'd100 + 14'(d1) * 14'd10 + 14'(d0);
    endfunction

    always_comb begin
        is_onehot = 1'b0;
        slot      = 2'd0;
        case (fnd_com)
            4'b1110: begin is_onehot = 1'b1; slot = 2'd0; end
            4'b1101: begin is_onehot = 1'b1; slot = 2'd1; end
            4'b1011: begin is_onehot = 1'b1; slot = 2'd2; end
            4'b0111: begin is_onehot = 1'b1; slot = 2'd3; end
            default: begin is_onehot = 1'b0; slot = 2'd0; end
        endcase
    end

    // Dwell tracking: a digit is sampled once, on the cycle its pair has held STABLE_CYC clocks.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        sample     = 1'b0;
        stab_next  = (state_q == SETTLE && same) ? stab_cnt_q + SW'(1) : SW'(1);
        if (state_q == HELD && same) begin
            state_d = HELD;
        end else if (!is_onehot) begin
            state_d    = IDLE;
            stab_cnt_d = '0;
        end else if (stab_next == SW'(STABLE_CYC)) begin
            state_d    = HELD;
            stab_cnt_d = stab_next;
            sample     = 1'b1;
        end else begin
            state_d    = SETTLE;
            stab_cnt_d = stab_next;
        end
    end

    always_comb begin
        dec         = seg_decode(fnd_data[6:0]);
        mask_d      = mask_q;
        err_d       = err_q;
        dig_d       = dig_q;
        value_d     = value_q;
        seg_err_d   = seg_err_q;
        value_vld_d = 1'b0;
        timeout_d   = 1'b0;
        tmo_cnt_d   = tmo_cnt_q + TW'(1);
        if (mask_q == 4'b1111) begin
            value_d     = bcd4_to_bin(dig_q[3], dig_q[2], dig_q[1], dig_q[0]);
            seg_err_d   = |err_q;
            value_vld_d = 1'b1;
            mask_d      = '0;
            err_d       = '0;
            tmo_cnt_d   = '0;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            timeout_d = 1'b1;
            mask_d    = '0;
            err_d     = '0;
            tmo_cnt_d = '0;
        end
        // A digit sampled on the completion/timeout cycle belongs to the next frame.
        if (sample) begin
            mask_d[slot] = 1'b1;
            err_d[slot]  = dec[4];
            dig_d[slot]  = dec[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            stab_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            mask_q      <= '0;
            err_q       <= '0;
            value_q     <= '0;
            value_vld_q <= 1'b0;
            seg_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
            value_q     <= value_d;
            value_vld_q <= value_vld_d;
            seg_err_q   <= seg_err_d;
            timeout_q   <= timeout_d;
        end
    end

    // Digit slots are only read once all four mask bits are set, so they need no reset.
    always_ff @(posedge clk) begin
        pair_q <= pair;
        dig_q  <= dig_d;
    end

    assign value     = value_q;
    assign value_vld = value_vld_q;
    assign seg_err   = seg_err_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: run-length reference model checked every cycle, plus directed frames.
module tb_fnd_scan_decoder;
    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;
    logic [13:0] value;
    logic        value_vld, seg_err, timeout;

    fnd_scan_decoder #(.STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .fnd_com(fnd_com), .fnd_data(fnd_data),
        .value(value), .value_vld(value_vld), .seg_err(seg_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int vld_cnt = 0, tmo_cnt = 0, last_vld_cyc = 0, last_tmo_cyc = 0;
    int last_val = 0, last_err = 0;
    bit chk_en = 0;

    // Reference model state: run length of the current (com,data) pair and per-slot captures.
    logic [10:0] m_prev;
    bit          m_have;
    int          m_run, m_age;
    bit          m_full [4];
    bit          m_bad [4];
    int          m_dig [4];
    int          exp_value = 0;
    bit          exp_vld = 0, exp_err = 0, exp_tmo = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int zero_pos(input logic [3:0] c);
        int n, p;
        n = 0;
        p = -1;
        for (int i = 0; i < 4; i++) if (!c[i]) begin n++; p = i; end
        return (n == 1) ? p : -1;
    endfunction

    function automatic int decode(input logic [6:0] s);
        logic [7:0] code;
        for (int i = 0; i < 10; i++) begin
            code = seg_tab[i];
            if (code[6:0] == s) return i;
        end
`ifdef FND_DEC_BLANK_AS_ZERO_EN
        if (s == 7'h7F) return 0;
`endif
        return -1;
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < 4; i++) begin m_full[i] = 0; m_bad[i] = 0; m_dig[i] = 0; end
    endtask

    task automatic model_reset();
        clear_frame();
        m_have = 0; m_run = 0; m_age = 0; m_prev = '0;
        exp_value = 0; exp_vld = 0; exp_err = 0; exp_tmo = 0;
    endtask

    task automatic model_step();
        logic [10:0] pair;
        int slot, d;
        bit done;
        pair = {fnd_com, fnd_data[6:0]};
        exp_vld = 0;
        exp_tmo = 0;
        m_age++;
        done = m_full[0] && m_full[1] && m_full[2] && m_full[3];
        if (done) begin
            exp_value = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
            exp_err = m_bad[0] || m_bad[1] || m_bad[2] || m_bad[3];
            exp_vld = 1;
            m_age = 0;
            clear_frame();
        end else if (m_age == TIMEOUT_CYC) begin
            exp_tmo = 1;
            m_age = 0;
            clear_frame();
        end
        if (m_have && pair == m_prev) m_run++;
        else m_run = 1;
        m_prev = pair;
        m_have = 1;
        slot = zero_pos(fnd_com);
        if (slot >= 0 && m_run == STABLE_CYC) begin
            d = decode(fnd_data[6:0]);
            m_full[slot] = 1;
            m_bad[slot] = (d < 0);
            m_dig[slot] = (d < 0) ? 0 : d;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else begin cyc++; model_step(); end
            #2;
            if (chk_en) begin
                chk("value", int'(value), exp_value);
                chk("value_vld", int'(value_vld), int'(exp_vld));
                chk("seg_err", int'(seg_err), int'(exp_err));
                chk("timeout", int'(timeout), int'(exp_tmo));
                if (value_vld) begin
                    vld_cnt++; last_val = int'(value); last_err = int'(seg_err); last_vld_cyc = cyc;
                end
                if (timeout) begin tmo_cnt++; last_tmo_cyc = cyc; end
            end
        end
    end

    task automatic drive(input logic [3:0] c, input logic [7:0] d, input int n);
        @(negedge clk);
        fnd_com = c;
        fnd_data = d;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic scan4(input int v, input int dwell);
        int pw [4];
        pw = '{1, 10, 100, 1000};
        for (int i = 0; i < 4; i++) drive(~(4'b0001 << i), seg_tab[(v / pw[i]) % 10], dwell);
    endtask

    initial begin
        int n0, t0, k0, r, n;
        logic [3:0] c;
        logic [7:0] d;
        rst = 1'b1; fnd_com = 4'hF; fnd_data = 8'hFF;
        #1 rst = 1'b0;
        #1 chk_en = 1;

        // Reset held while the bus toggles.
        for (int i = 0; i < 6; i++) drive(~(4'b0001 << (i % 4)), seg_tab[i], 1);
        chk("rst_value", int'(value), 0);
        chk("rst_vld", int'(value_vld), 0);
        chk("rst_seg_err", int'(seg_err), 0);
        chk("rst_timeout", int'(timeout), 0);
        @(negedge clk); rst = 1'b1;

        // Plain 1234 scan and its latency.
        n0 = vld_cnt;
        drive(4'b1110, 8'h99, 8); drive(4'b1101, 8'hB0, 8); drive(4'b1011, 8'hA4, 8);
        drive(4'b0111, 8'hF9, 1); t0 = cyc; repeat (7) @(negedge clk);
        drive(4'hF, 8'hFF, 3);
        chk("scan1234_cnt", vld_cnt, n0 + 1);
        chk("scan1234_val", last_val, 1234);
        chk("scan1234_err", last_err, 0);
        chk("scan1234_lat", last_vld_cyc - t0, 5);

        // Short glitch dwells and blank gaps are ignored.
        n0 = vld_cnt;
        drive(4'b1110, 8'h99, 8); drive(4'hF, 8'hFF, 3);
        drive(4'b1101, seg_tab[7], 2); drive(4'hF, 8'hFF, 2);
        drive(4'b1101, 8'hB0, 8); drive(4'hF, 8'hFF, 1);
        drive(4'b1011, 8'hA4, 8); drive(4'hF, 8'hFF, 3);
        drive(4'b0111, seg_tab[8], 3); drive(4'b0111, 8'hF9, 8); drive(4'hF, 8'hFF, 3);
        chk("glitch_cnt", vld_cnt, n0 + 1);
        chk("glitch_val", last_val, 1234);
        chk("glitch_err", last_err, 0);

        // Blank thousands digit.
        n0 = vld_cnt;
        drive(4'b1110, 8'h99, 8); drive(4'b1101, 8'hB0, 8); drive(4'b1011, 8'hA4, 8);
        drive(4'b0111, 8'hFF, 8); drive(4'hF, 8'hFF, 3);
        chk("blank_cnt", vld_cnt, n0 + 1);
        chk("blank_val", last_val, 234);
`ifdef FND_DEC_BLANK_AS_ZERO_EN
        chk("blank_err", last_err, 0);
`else
        chk("blank_err", last_err, 1);
`endif

        // Timeout after a partial frame, then a full 9999 frame.
        n0 = vld_cnt; k0 = tmo_cnt;
        drive(4'b1110, seg_tab[5], 9); drive(4'b1101, seg_tab[6], 9);
        for (int i = 0; i < 150; i++) begin
            drive(4'hF, 8'hFF, 1);
            if (tmo_cnt != k0) break;
        end
        chk("tmo_seen", tmo_cnt, k0 + 1);
        chk("tmo_at", last_tmo_cyc - last_vld_cyc, TIMEOUT_CYC);
        chk("tmo_no_vld", vld_cnt, n0);
        scan4(9999, 8); drive(4'hF, 8'hFF, 3);
        chk("scan9999_cnt", vld_cnt, n0 + 1);
        chk("scan9999_val", last_val, 9999);

        // Reset after three captured digits clears the mask (dp low on the refill digits).
        drive(4'b0111, seg_tab[9], 8); drive(4'b1011, seg_tab[9], 8); drive(4'b1101, seg_tab[9], 8);
        @(negedge clk); rst = 1'b0; fnd_com = 4'hF; fnd_data = 8'hFF;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n0 = vld_cnt;
        drive(4'b1110, seg_tab[1] & 8'h7F, 8); drive(4'hF, 8'hFF, 10);
        chk("rst_mask_clear", vld_cnt, n0);
        drive(4'b1101, seg_tab[2] & 8'h7F, 8); drive(4'b1011, seg_tab[3] & 8'h7F, 8);
        drive(4'b0111, seg_tab[4] & 8'h7F, 8); drive(4'hF, 8'hFF, 3);
        chk("refill_cnt", vld_cnt, n0 + 1);
        chk("refill_val", last_val, 4321);

        // Randomized bus traffic against the model.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 60) c = ~(4'b0001 << $urandom_range(0, 3));
            else if (r < 80) c = 4'hF;
            else c = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 99);
            if (r < 70) d = seg_tab[$urandom_range(0, 9)];
            else if (r < 80) d = 8'hFF;
            else d = {1'b1, 7'($urandom_range(0, 127))};
            n = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : $urandom_range(4, 10);
            drive(c, d, n);
        end
        drive(4'hF, 8'hFF, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
